// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling from a baud
// counter, and a single-word output register with parity/framing/overrun
// status.
//
// Handshake: a word is transferred on every rising clock edge where
// rx_data_valid && rx_ready. While rx_data_valid is high and not yet
// accepted, rx_data_out, rx_parity_err and rx_frame_err hold steady. A
// new frame arriving while the held word is unaccepted is dropped and
// flagged with a one-cycle rx_overrun pulse.
module uart_rx #(
    parameter int BAUD_RATE   = 115200,
    parameter int CLK_RATE    = 100000000,
    parameter int WORD_WIDTH  = 8,
    parameter int EVEN_PARITY = 0
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  rx_data_in,
    output logic [WORD_WIDTH-1:0] rx_data_out,
    output logic                  rx_data_valid,
    input  logic                  rx_ready,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    output logic                  rx_overrun,
    output logic                  rx_busy,
    output logic [2:0]            dbg_state
);

    localparam int BAUD_COUNTER_MAX = CLK_RATE / BAUD_RATE;
    localparam int HALF             = BAUD_COUNTER_MAX / 2;
    localparam int CNT_W            = ($clog2(BAUD_COUNTER_MAX) > 0) ? $clog2(BAUD_COUNTER_MAX) : 1;
    localparam int BIT_W            = $clog2(WORD_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [CNT_W-1:0]      r_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [WORD_WIDTH-1:0] r_shift;
    logic                  r_par_bit;
    logic [WORD_WIDTH-1:0] r_data_out;
    logic                  r_valid;
    logic                  r_parity_err;
    logic                  r_frame_err;
    logic                  r_overrun;

    logic                  w_line;
    logic                  w_term;
    logic                  w_half;
    logic                  w_last_bit;
    logic                  w_stop_sample;
    logic                  w_load;
    logic                  w_par_exp;

    assign w_line        = r_sync2;
    assign w_term        = (r_cnt == CNT_W'(BAUD_COUNTER_MAX - 1));
    assign w_half        = (r_cnt == CNT_W'(HALF - 1));
    assign w_last_bit    = (r_bit_cnt == BIT_W'(WORD_WIDTH - 1));
    assign w_stop_sample = (r_state == S_STOP) && w_term;
    // The output register may take a new word if it is empty or being emptied now.
    assign w_load        = !r_valid || rx_ready;
    assign w_par_exp     = (EVEN_PARITY != 0) ? ^r_shift : ~^r_shift;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_data_in;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; START re-checks the line at half a bit to reject glitches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_line) w_next_state = S_START;
            end
            S_START: begin
                if (w_half) w_next_state = w_line ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_term && w_last_bit) w_next_state = S_PARITY;
            end
            S_PARITY: begin
                if (w_term) w_next_state = S_STOP;
            end
            S_STOP: begin
                if (w_term) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Baud counter: restarts on every state change and on its terminal count.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((w_next_state != r_state) || w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Data/parity capture: shift data in LSB first, then hold the parity sample.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
        end else begin
            if (r_state != S_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_term) begin
                r_shift   <= {w_line, r_shift[WORD_WIDTH-1:1]};
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
            if ((r_state == S_PARITY) && w_term) begin
                r_par_bit <= w_line;
            end
        end
    end

    // Output word register with status flags, handshake and overrun pulse.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_stop_sample && w_load) begin
                r_data_out   <= r_shift;
                r_parity_err <= (r_par_bit != w_par_exp);
                r_frame_err  <= ~w_line;
                r_valid      <= 1'b1;
            end else begin
                if (w_stop_sample) begin
                    r_overrun <= 1'b1;
                end
                if (r_valid && rx_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign rx_data_out   = r_data_out;
    assign rx_data_valid = r_valid;
    assign rx_parity_err = r_parity_err;
    assign rx_frame_err  = r_frame_err;
    assign rx_overrun    = r_overrun;
    assign rx_busy       = (r_state != S_IDLE);
    assign dbg_state     = r_state;

endmodule
